rom_loader: RTL

Front-end stage between the HPS ioctl download stream and the SDRAM write port. It takes ROM bytes from the HPS, hands each one to the SDRAM controller over a toggle handshake, and back-pressures the HPS with `ioctl_wait`. At end of download it decides whether the image carries a 512-byte copier header, and derives the cartridge address mask, payload size and console type used by the read path.

---
 rtl/rom_loader.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rom_loader.sv
// rom_loader
//
// Sits between the HPS ioctl download stream and the SDRAM write port. Each
// ROM byte from the HPS becomes one SDRAM write on a toggle handshake.
// ioctl_wait stalls the HPS while that write is outstanding. At the end of
// a download the block decides whether a copier header is present. It then
// derives the payload size, the cartridge read mask and the console type.
//
// Optional feature: define ROM_LOADER_CHECKSUM_EN to build the payload
// checksum accumulators. Without it rom_sum is tied to zero.
//
// Parameters:
//   AW        SDRAM byte-address width
//   HDR_SIZE  copier header length in bytes (power of two below 16384)
//
// Ports:
//   clk_sys         system clock
//   reset           synchronous, active-high reset
//   ioctl_download  high for the whole download
//   ioctl_index     file index; [4:0]==2 marks a Game Gear image
//   ioctl_wr        one-cycle byte strobe
//   ioctl_addr      byte address of ioctl_dout
//   ioctl_dout      byte data
//   ioctl_wait      stall request back to the HPS
//   mem_req         SDRAM write request toggle
//   mem_ack         SDRAM acknowledge toggle (done when equal to mem_req)
//   mem_addr        SDRAM write address
//   mem_din         SDRAM write data
//   rom_size        payload size in bytes, header excluded
//   hdr_skip        copier header present; reads are offset by HDR_SIZE
//   cart_mask       read-address mask
//   gg              Game Gear image
//   oversize        sticky: a byte was dropped for being out of range
//   load_done       one-cycle pulse when the results above are valid
//   rom_sum         payload checksum (zero unless the checksum is built)

module rom_loader #(
  parameter int AW       = 22,
  parameter int HDR_SIZE = 512
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          ioctl_download,
  input  logic [7:0]    ioctl_index,
  input  logic          ioctl_wr,
  input  logic [24:0]   ioctl_addr,
  input  logic [7:0]    ioctl_dout,
  output logic          ioctl_wait,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic [AW-1:0] mem_addr,
  output logic [7:0]    mem_din,
  output logic [AW:0]   rom_size,
  output logic          hdr_skip,
  output logic [AW-1:0] cart_mask,
  output logic          gg,
  output logic          oversize,
  output logic          load_done,
  output logic [15:0]   rom_sum
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WR,
    WAIT_ACK,
    DRAIN,
    FINISH
  } state_t;

  // One bit wider than ioctl_addr so that AW up to 25 still compares correctly.
  localparam logic [25:0] ADDR_LIMIT = 26'(1) << AW;
  localparam logic [AW:0] HDR_CNT    = (AW+1)'(HDR_SIZE);
  localparam logic [13:0] HDR_LOW    = 14'(HDR_SIZE);
  localparam logic [AW:0] CNT_ONE    = (AW+1)'(1);

  state_t        state_q;
  state_t        state_d;
  logic          dl_q;
  logic          dl_start;
  logic          dl_end;
  logic          ack_match;
  logic          addr_in_range;
  logic          accept_wr;
  logic          drop_wr;
  logic          complete_wr;
  logic [AW:0]   cnt_q;
  logic [AW:0]   cnt_cand;
  logic          hdr_next;
  logic [AW:0]   size_next;
  logic [AW:0]   size_m1;
  logic [AW-1:0] mask_next;
  logic          fill;
  logic          unused_bits;

  assign dl_start      = ~dl_q & ioctl_download;
  assign dl_end        = dl_q & ~ioctl_download;
  assign ack_match     = (mem_ack == mem_req);
  assign addr_in_range = ({1'b0, ioctl_addr} < ADDR_LIMIT);
  // mem_addr still holds the address of the write being completed.
  assign cnt_cand      = {1'b0, mem_addr} + CNT_ONE;
  assign unused_bits   = ^{ioctl_index[7:5], size_m1[AW]};

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and per-cycle control. Download start overrides everything.
  // A strobe that lands together with download end is still taken; the end
  // is then finished off through DRAIN.
  always_comb begin
    state_d     = state_q;
    accept_wr   = 1'b0;
    drop_wr     = 1'b0;
    complete_wr = 1'b0;
    if (dl_start) begin
      state_d = WAIT_WR;
    end else begin
      case (state_q)
        IDLE: begin
          state_d = IDLE;
        end
        WAIT_WR: begin
          if (ioctl_wr && addr_in_range) begin
            accept_wr = 1'b1;
            state_d   = dl_end ? DRAIN : WAIT_ACK;
          end else begin
            drop_wr = ioctl_wr;
            if (dl_end) begin
              state_d = FINISH;
            end
          end
        end
        WAIT_ACK: begin
          // Strobes here break the protocol and are ignored.
          if (ack_match) begin
            complete_wr = 1'b1;
            state_d     = dl_end ? FINISH : WAIT_WR;
          end else if (dl_end) begin
            state_d = DRAIN;
          end
        end
        DRAIN: begin
          if (ack_match) begin
            complete_wr = 1'b1;
            state_d     = FINISH;
          end
        end
        FINISH: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // End-of-download results, computed from the byte count.
  // The mask is (size-1) with every bit below its MSB filled in.
  always_comb begin
    fill      = 1'b0;
    hdr_next  = (cnt_q[13:0] == HDR_LOW) && (cnt_q > HDR_CNT);
    size_next = cnt_q - (hdr_next ? HDR_CNT : '0);
    size_m1   = size_next - CNT_ONE;
    mask_next = '0;
    for (int i = AW - 1; i >= 0; i--) begin
      fill         = fill | size_m1[i];
      mask_next[i] = fill;
    end
    if (size_next == '0) begin
      mask_next = '0;
    end
  end

  // Reset puts mem_req back in line with mem_ack so that no request is left
  // hanging. It also drops ioctl_wait.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      dl_q       <= 1'b0;
      ioctl_wait <= 1'b0;
      mem_req    <= mem_ack;
      mem_addr   <= '0;
      mem_din    <= '0;
      cnt_q      <= '0;
      rom_size   <= '0;
      hdr_skip   <= 1'b0;
      cart_mask  <= '0;
      gg         <= 1'b0;
      oversize   <= 1'b0;
      load_done  <= 1'b0;
    end else begin
      dl_q      <= ioctl_download;
      load_done <= 1'b0;
      if (dl_start) begin
        cnt_q      <= '0;
        hdr_skip   <= 1'b0;
        cart_mask  <= '0;
        rom_size   <= '0;
        oversize   <= 1'b0;
        ioctl_wait <= 1'b0;
        gg         <= (ioctl_index[4:0] == 5'd2);
      end else begin
        if (accept_wr) begin
          mem_addr   <= ioctl_addr[AW-1:0];
          mem_din    <= ioctl_dout;
          mem_req    <= ~mem_req;
          ioctl_wait <= 1'b1;
        end
        if (drop_wr) begin
          oversize <= 1'b1;
        end
        // Bytes may arrive out of order, so keep the highest end address.
        if (complete_wr) begin
          ioctl_wait <= 1'b0;
          if (cnt_cand > cnt_q) begin
            cnt_q <= cnt_cand;
          end
        end
        if (state_q == FINISH) begin
          hdr_skip  <= hdr_next;
          rom_size  <= size_next;
          cart_mask <= mask_next;
          load_done <= 1'b1;
        end
      end
    end
  end

`ifdef ROM_LOADER_CHECKSUM_EN
  logic [15:0] sum_all_q;
  logic [15:0] sum_hdr_q;
  logic        is_hdr_byte;

  assign is_hdr_byte = (ioctl_addr < 25'(HDR_SIZE));

  // sum_hdr tracks the header bytes alone. They can then be taken out of
  // the total once we know a header was actually present.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      sum_all_q <= '0;
      sum_hdr_q <= '0;
      rom_sum   <= '0;
    end else if (dl_start) begin
      sum_all_q <= '0;
      sum_hdr_q <= '0;
    end else begin
      if (accept_wr) begin
        sum_all_q <= sum_all_q + {8'h00, ioctl_dout};
        if (is_hdr_byte) begin
          sum_hdr_q <= sum_hdr_q + {8'h00, ioctl_dout};
        end
      end
      if (state_q == FINISH) begin
        rom_sum <= sum_all_q - (hdr_next ? sum_hdr_q : 16'h0000);
      end
    end
  end
`else
  assign rom_sum = 16'h0000;
`endif

endmodule
